// File: rtl/dual_slope_sequencer.sv
// rtl/dual_slope_sequencer.sv - dual-slope ADC conversion sequencer (auto-zero, integrate, de-integrate, count)
// Define CONT_CONV_EN for level-sensitive start with back-to-back conversions.
module dual_slope_sequencer #(
   parameter int CNT_W = 14,
   parameter int N_AZ  = 100,
   parameter int N_INT = 1000,
   parameter int N_MAX = 2000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             vint_z,
   output logic [2:0]       ch,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] result,
   output logic             overrange
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_AZ    = 3'd1;
   localparam logic [2:0] S_GAP1  = 3'd2;
   localparam logic [2:0] S_INT   = 3'd3;
   localparam logic [2:0] S_GAP2  = 3'd4;
   localparam logic [2:0] S_DEINT = 3'd5;
   localparam logic [2:0] S_DONE  = 3'd6;

   localparam logic [CNT_W-1:0] AZ_LAST  = CNT_W'(N_AZ - 1);
   localparam logic [CNT_W-1:0] INT_LAST = CNT_W'(N_INT - 1);
   localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(N_MAX - 1);

   logic [2:0]       state;
   logic [2:0]       state_nxt;
   logic [2:0]       ch_nxt;
   logic [CNT_W-1:0] cnt;
   logic             vint_z_m;
   logic             vint_z_s;
   logic             trigger;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vint_z_m <= 1'b0;
         vint_z_s <= 1'b0;
      end else begin
         vint_z_m <= vint_z;
         vint_z_s <= vint_z_m;
      end
   end

`ifdef CONT_CONV_EN
   assign trigger = start;
`else
   logic start_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         start_q <= 1'b0;
      end else begin
         start_q <= start;
      end
   end

   assign trigger = start & ~start_q;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (trigger) state_nxt = S_AZ;
         S_AZ:    if (cnt == AZ_LAST) state_nxt = S_GAP1;
         S_GAP1:  state_nxt = S_INT;
         S_INT:   if (cnt == INT_LAST) state_nxt = S_GAP2;
         S_GAP2:  state_nxt = S_DEINT;
         S_DEINT: if (vint_z_s || (cnt == MAX_LAST)) state_nxt = S_DONE;
         S_DONE: begin
`ifdef CONT_CONV_EN
            state_nxt = start ? S_AZ : S_IDLE;
`else
            state_nxt = S_IDLE;
`endif
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Switch drive is decoded from the next state so ch lines up with state.
   always_comb begin
      case (state_nxt)
         S_IDLE, S_AZ: ch_nxt = 3'b100;
         S_INT:        ch_nxt = 3'b001;
         S_DEINT:      ch_nxt = 3'b010;
         default:      ch_nxt = 3'b000;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         ch        <= 3'b100;
         done      <= 1'b0;
         result    <= '0;
         overrange <= 1'b0;
      end else begin
         state <= state_nxt;
         ch    <= ch_nxt;
         done  <= (state_nxt == S_DONE);
         cnt   <= ((state_nxt != state) || (state_nxt == S_IDLE)) ? '0 : cnt + 1'b1;
         // A crossing on the final timeout cycle still counts as in range.
         if (state == S_DEINT) begin
            if (vint_z_s) begin
               result    <= cnt;
               overrange <= 1'b0;
            end else if (cnt == MAX_LAST) begin
               result    <= MAX_LAST;
               overrange <= 1'b1;
            end
         end
      end
   end

   assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_dual_slope_sequencer.sv
// tb/tb_dual_slope_sequencer.sv - self-checking bench for dual_slope_sequencer
// Define CONT_CONV_EN to exercise the continuous-conversion build.
module tb_dual_slope_sequencer;

   localparam int CNT_W = 8;
   localparam int N_AZ  = 4;
   localparam int N_INT = 10;
   localparam int N_MAX = 20;
   localparam int D0    = N_AZ + N_INT + 2;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             start = 1'b0;
   logic             vint_z = 1'b0;
   logic [2:0]       ch;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] result;
   logic             overrange;

   int checks = 0;
   int errors = 0;
   int done_seen = 0;

   dual_slope_sequencer #(
      .CNT_W(CNT_W), .N_AZ(N_AZ), .N_INT(N_INT), .N_MAX(N_MAX)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .vint_z(vint_z),
      .ch(ch), .busy(busy), .done(done), .result(result), .overrange(overrange)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_done(input string name, input int budget, output int took);
      took = -1;
      for (int i = 0; i < budget; i++) begin
         tick(1);
         if (done === 1'b1) begin
            took = i;
            break;
         end
      end
      if (took < 0) begin
         checks++;
         errors++;
         $display("FAIL %s: done still 0 after %0d cycles, expected 1", name, budget);
      end
   endtask

   function automatic int seq1(input int i);
      if (i < 4)       return 4;
      else if (i == 4) return 0;
      else if (i < 15) return 1;
      else if (i == 15) return 0;
      else if (i < 24) return 2;
      else if (i == 24) return 0;
      else             return 4;
   endfunction

   // Reference model: position p counts cycles from the first auto-zero cycle.
   logic vz_hist [0:1023];
   int   cyc = 0;
   bit   m_idle = 1'b1;
   bit   m_done = 1'b0;
   int   m_p = 0;
   int   m_res = 0;
   int   m_ov = 0;
   bit   m_prev_start = 1'b0;

   always @(negedge clk) begin
      int exp_ch;
      int k;
      cyc++;
      vz_hist[cyc % 1024] = reset ? 1'b0 : vint_z;
      if (done === 1'b1) done_seen++;
      if (reset) begin
         m_idle = 1'b1; m_done = 1'b0; m_p = 0; m_res = 0; m_ov = 0; m_prev_start = 1'b0;
         check($sformatf("rst_ch@%0d", cyc), ch, 3'b100);
         check($sformatf("rst_busy@%0d", cyc), busy, 0);
         check($sformatf("rst_done@%0d", cyc), done, 0);
         check($sformatf("rst_result@%0d", cyc), result, 0);
         check($sformatf("rst_ovr@%0d", cyc), overrange, 0);
      end else begin
         if (m_idle)                    exp_ch = 4;
         else if (m_done)               exp_ch = 0;
         else if (m_p < N_AZ)           exp_ch = 4;
         else if (m_p == N_AZ)          exp_ch = 0;
         else if (m_p <= N_AZ + N_INT)  exp_ch = 1;
         else if (m_p == D0 - 1)        exp_ch = 0;
         else                           exp_ch = 2;
         check($sformatf("m_ch@%0d", cyc), ch, exp_ch);
         check($sformatf("m_busy@%0d", cyc), busy, m_idle ? 0 : 1);
         check($sformatf("m_done@%0d", cyc), done, m_done ? 1 : 0);
         check($sformatf("m_result@%0d", cyc), result, m_res);
         check($sformatf("m_ovr@%0d", cyc), overrange, m_ov);

         if (m_idle) begin
`ifdef CONT_CONV_EN
            if (start) begin m_idle = 1'b0; m_p = 0; end
`else
            if (start && !m_prev_start) begin m_idle = 1'b0; m_p = 0; end
`endif
         end else if (m_done) begin
            m_done = 1'b0;
            m_idle = 1'b1;
`ifdef CONT_CONV_EN
            if (start) begin m_idle = 1'b0; m_p = 0; end
`endif
         end else if (m_p >= D0) begin
            k = m_p - D0;
            if (vz_hist[(cyc - 2) % 1024]) begin
               m_res = k; m_ov = 0; m_done = 1'b1;
            end else if (k == N_MAX - 1) begin
               m_res = N_MAX - 1; m_ov = 1; m_done = 1'b1;
            end else begin
               m_p++;
            end
         end else begin
            m_p++;
         end
         m_prev_start = start;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int took;
      int d_before;

      tick(2);
      check("reset_ch", ch, 3'b100);
      check("reset_busy", busy, 0);
      check("reset_result", result, 0);
      reset = 1'b0;
      tick(2);

      // Single conversion, crossing seen at DEINT cycle 7.
      start = 1'b1;
      for (int i = 0; i < 26; i++) begin
         tick(1);
         start = 1'b0;
         if (i == 21) vint_z = 1'b1;
         if (i == 24) vint_z = 1'b0;
         check($sformatf("t1_ch[%0d]", i), ch, seq1(i));
         check($sformatf("t1_busy[%0d]", i), busy, (i < 25) ? 1 : 0);
         check($sformatf("t1_done[%0d]", i), done, (i == 24) ? 1 : 0);
         if (i == 24) begin
            check("t1_result", result, 7);
            check("t1_ovr", overrange, 0);
         end
      end

      // Timeout: no crossing at all.
      tick(3);
      start = 1'b1; tick(1); start = 1'b0;
      wait_done("t2_done", 60, took);
      check("t2_done_time", took, 35);
      check("t2_result", result, 19);
      check("t2_ovr", overrange, 1);
      tick(1);
      check("t2_ch_after", ch, 3'b100);
      check("t2_busy_after", busy, 0);

      // Crossing lands exactly on the timeout cycle.
      tick(3);
      start = 1'b1; tick(1); start = 1'b0;
      tick(33);
      vint_z = 1'b1;
      wait_done("t3_done", 20, took);
      vint_z = 1'b0;
      check("t3_done_time", took, 2);
      check("t3_result", result, 19);
      check("t3_ovr", overrange, 0);

      // Reset in the middle of the integrate phase.
      tick(3);
      start = 1'b1; tick(1); start = 1'b0;
      tick(8);
      check("t4_in_int", ch, 3'b001);
      #2 reset = 1'b1;
      #1;
      check("t4_rst_ch", ch, 3'b100);
      check("t4_rst_busy", busy, 0);
      d_before = done_seen;
      tick(2);
      reset = 1'b0;
      tick(40);
      check("t4_no_done", done_seen - d_before, 0);
      check("t4_result", result, 0);

      // Start pulse while busy is ignored.
      start = 1'b1; tick(1); start = 1'b0;
      tick(8);
      start = 1'b1; tick(1); start = 1'b0;
      d_before = done_seen;
      wait_done("t5_done", 60, took);
      check("t5_done_time", took, 26);
      tick(40);
      check("t5_one_done", done_seen - d_before, 1);
      check("t5_idle", busy, 0);

`ifndef CONT_CONV_EN
      // Held start gives a single conversion.
      d_before = done_seen;
      start = 1'b1;
      tick(120);
      check("t5_held_one_done", done_seen - d_before, 1);
      check("t5_held_idle", busy, 0);
      start = 1'b0;
      tick(3);
`else
      // Back-to-back conversions, 25 cycles each.
      start = 1'b1;
      for (int i = 0; i < 80; i++) begin
         tick(1);
         if (i >= 70) start = 1'b0;
         vint_z = (i < 75) && ((i % 25) >= 21) && ((i % 25) < 24);
         check($sformatf("t6_done[%0d]", i), done, ((i % 25) == 24 && i < 75) ? 1 : 0);
         check($sformatf("t6_busy[%0d]", i), busy, (i < 75) ? 1 : 0);
      end
      check("t6_result", result, 7);
      tick(3);
`endif

      // Randomized conversions checked by the model.
      for (int n = 0; n < 30; n++) begin
         int rise;
         int g_at;
         int g_len;
         int hold;
         rise  = $urandom_range(0, D0 + N_MAX + 2);
         g_at  = $urandom_range(N_AZ + 1, N_AZ + N_INT);
         g_len = $urandom_range(0, 2);
         hold  = $urandom_range(1, 3);
         start = 1'b1;
         tick(1);
         took = -1;
         for (int p = 0; p < 60; p++) begin
            start  = (p < hold - 1);
            vint_z = (p >= rise) || (p >= g_at && p < g_at + g_len);
            tick(1);
            if (done === 1'b1) begin
               took = p;
               break;
            end
         end
         if (took < 0) begin
            checks++;
            errors++;
            $display("FAIL rnd_done[%0d]: done still 0 after 60 cycles, expected 1", n);
         end
         start  = 1'b0;
         vint_z = 1'b0;
         tick($urandom_range(2, 5));
      end

      tick(5);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
